spi_master_byte: RTL

//  Mode-0 (CPOL=0, CPHA=0) SPI master that drives SCK/MOSI/SSEL and samples MISO
//  for the 8-bit SPI slave on the same board. Transfers are MSB first.

---
 rtl/spi_master_byte_if.sv | 20 ++
 rtl/spi_master_byte.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/spi_master_byte_if.sv
// Byte stream between a user and spi_master_byte: tx bytes in with tx_last
// framing, received bytes out with a one-cycle rx_valid strobe.
interface spi_master_byte_if;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (
    output tx_data, tx_last, tx_valid,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_last, tx_valid,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_master_byte.sv
// Mode-0 SPI master, MSB first, one SSEL-low window per tx_last-terminated frame.
// Optional SPI_MASTER_LOOPBACK_EN adds a `loopback` input feeding MOSI back into rx.
module spi_master_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_master_byte_if.slave bus,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic             loopback,
`endif
  output logic             busy,
  output logic             SCK,
  output logic             MOSI,
  input  logic             MISO,
  output logic             SSEL
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("spi_master_byte: CLK_DIV must be at least 4");
  end

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, END, WAIT, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [2:0]       bit_reg, bit_next;
  logic [6:0]       tx_sh_reg, tx_sh_next;
  logic             last_reg, last_next;
  logic [6:0]       rx_sh_reg, rx_sh_next;
  logic [7:0]       rx_data_reg, rx_data_next;
  logic             rx_valid_reg, rx_valid_next;
  logic             sck_reg, sck_next;
  logic             mosi_reg, mosi_next;
  logic             ssel_reg, ssel_next;
  logic [1:0]       miso_sync_reg;

  logic tx_ready;
  logic accept;
  logic phase_done;
  logic rx_bit;

  assign tx_ready   = (state_reg == IDLE) || (state_reg == WAIT);
  assign accept     = tx_ready && bus.tx_valid;
  assign phase_done = (div_reg == DIV_LAST);

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = loopback ? mosi_reg : miso_sync_reg[1];
`else
  assign rx_bit = miso_sync_reg[1];
`endif

  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    bit_next      = bit_reg;
    tx_sh_next    = tx_sh_reg;
    last_next     = last_reg;
    rx_sh_next    = rx_sh_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    sck_next      = sck_reg;
    mosi_next     = mosi_reg;
    ssel_next     = ssel_reg;

    // Timed states all run for exactly CLK_DIV cycles; IDLE/WAIT park the divider at 0.
    if (state_reg != IDLE && state_reg != WAIT) begin
      div_next = phase_done ? '0 : div_reg + 1'b1;
    end

    case (state_reg)
      IDLE, WAIT: begin
        if (accept) begin
          state_next = SETUP;
          tx_sh_next = bus.tx_data[6:0];
          last_next  = bus.tx_last;
          mosi_next  = bus.tx_data[7];
          ssel_next  = 1'b0;
          sck_next   = 1'b0;
          div_next   = '0;
          bit_next   = 3'd0;
        end
      end
      SETUP: begin
        if (phase_done) begin
          state_next = HIGH;
          sck_next   = 1'b1;
        end
      end
      HIGH: begin
        if (phase_done) begin
          rx_sh_next = {rx_sh_reg[5:0], rx_bit};
          sck_next   = 1'b0;
          if (bit_reg == 3'd7) begin
            state_next    = END;
            bit_next      = 3'd0;
            rx_data_next  = {rx_sh_reg, rx_bit};
            rx_valid_next = 1'b1;
          end else begin
            state_next = LOW;
            bit_next   = bit_reg + 3'd1;
            mosi_next  = tx_sh_reg[6];
            tx_sh_next = {tx_sh_reg[5:0], 1'b0};
          end
        end
      end
      LOW: begin
        if (phase_done) begin
          state_next = HIGH;
          sck_next   = 1'b1;
        end
      end
      END: begin
        if (phase_done) begin
          if (last_reg) begin
            state_next = HOLD;
            ssel_next  = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      HOLD: begin
        if (phase_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      div_reg       <= '0;
      bit_reg       <= 3'd0;
      tx_sh_reg     <= '0;
      last_reg      <= 1'b0;
      rx_sh_reg     <= '0;
      rx_data_reg   <= 8'h00;
      rx_valid_reg  <= 1'b0;
      sck_reg       <= 1'b0;
      mosi_reg      <= 1'b0;
      ssel_reg      <= 1'b1;
      miso_sync_reg <= 2'b00;
    end else begin
      state_reg     <= state_next;
      div_reg       <= div_next;
      bit_reg       <= bit_next;
      tx_sh_reg     <= tx_sh_next;
      last_reg      <= last_next;
      rx_sh_reg     <= rx_sh_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      sck_reg       <= sck_next;
      mosi_reg      <= mosi_next;
      ssel_reg      <= ssel_next;
      miso_sync_reg <= {miso_sync_reg[0], MISO};
    end
  end

  assign bus.tx_ready = tx_ready;
  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;
  assign busy         = (state_reg != IDLE);
  assign SCK          = sck_reg;
  assign MOSI         = mosi_reg;
  assign SSEL         = ssel_reg;

endmodule
